// File: rtl/sort_drain_checker_if.sv
// Handshake bundle between the drain checker and its environment: sorter status/data
// in, pop toggle, result stream and drain statistics out.
interface sort_drain_checker_if #(
    parameter int DW = 16,
    parameter int CW = 8
);
    logic          enable;
    logic          start;
    logic          s_idle;
    logic          s_empty;
    logic [DW-1:0] s_dout;
    logic          s_pop;
    logic          busy;
    logic          done;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic [DW-1:0] vmin;
    logic [DW-1:0] vmax;
    logic          order_err;
    logic [CW-1:0] err_index;

    modport master (
        output enable, start, s_idle, s_empty, s_dout,
        input  s_pop, busy, done, m_valid, m_data, count, vmin, vmax, order_err, err_index
    );

    modport slave (
        input  enable, start, s_idle, s_empty, s_dout,
        output s_pop, busy, done, m_valid, m_data, count, vmin, vmax, order_err, err_index
    );
endinterface

// File: rtl/sort_drain_checker.sv
// Drains a sorter with toggle-encoded pops, forwards each sampled word as a one-cycle
// valid stream and keeps count/min/max plus a sticky first-order-violation record.
module sort_drain_checker #(
    parameter int DW       = 16,
    parameter int CW       = 8,
    parameter int POP_WAIT = 2,
    parameter int GAP      = 10
) (
    input  logic               clk,
    input  logic               rst,
    sort_drain_checker_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        CHECK,
        GAP_WAIT,
        POP,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    localparam int WMAX = (GAP > POP_WAIT) ? GAP : POP_WAIT;
    localparam int WW   = $clog2(WMAX + 2);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [WW-1:0] GAP_LD  = WW'(GAP);
    localparam logic [WW-1:0] WAIT_LD = WW'(POP_WAIT);

    // Saturating element-counter increment.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t        state_r;
    logic          start_q_r;
    logic [WW-1:0] wait_r;
    logic          s_pop_r;
    logic          busy_r;
    logic          done_r;
    logic          m_valid_r;
    logic [DW-1:0] m_data_r;
    logic [CW-1:0] count_r;
    logic [DW-1:0] vmin_r;
    logic [DW-1:0] vmax_r;
    logic          order_err_r;
    logic [CW-1:0] err_index_r;

    logic          start_edge_s;
    logic          violation_s;
    logic [CW-1:0] count_next_s;

    // Command edge and order-violation detection on the word being sampled.
    always_comb begin
        start_edge_s = bus.start ^ start_q_r;
        count_next_s = sat_inc(count_r);
        if ((count_r != {CW{1'b0}}) && (bus.s_dout < m_data_r) && !order_err_r) begin
            violation_s = 1'b1;
        end else begin
            violation_s = 1'b0;
        end
    end

    // Start history tracks the pin even when disabled, so stale edges are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q_r <= 1'b0;
        end else begin
            start_q_r <= bus.start;
        end
    end

    // Drain sequencer with registered outputs and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            wait_r      <= {WW{1'b0}};
            s_pop_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            m_valid_r   <= 1'b0;
            m_data_r    <= {DW{1'b0}};
            count_r     <= {CW{1'b0}};
            vmin_r      <= {DW{1'b1}};
            vmax_r      <= {DW{1'b0}};
            order_err_r <= 1'b0;
            err_index_r <= {CW{1'b0}};
        end else if (!bus.enable) begin
            done_r    <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            m_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_edge_s) begin
                        count_r     <= {CW{1'b0}};
                        vmin_r      <= {DW{1'b1}};
                        vmax_r      <= {DW{1'b0}};
                        order_err_r <= 1'b0;
                        err_index_r <= {CW{1'b0}};
                        busy_r      <= 1'b1;
                        state_r     <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (bus.s_idle) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.s_empty) begin
                        state_r <= DONE;
                    end else begin
                        wait_r  <= GAP_LD;
                        state_r <= GAP_WAIT;
                    end
                end
                GAP_WAIT: begin
                    // Leaving as the counter reaches zero puts POP GAP+1 cycles after CHECK.
                    if (wait_r > WW'(1)) begin
                        wait_r <= wait_r - WW'(1);
                    end else begin
                        wait_r  <= {WW{1'b0}};
                        state_r <= POP;
                    end
                end
                POP: begin
                    s_pop_r <= ~s_pop_r;
                    wait_r  <= WAIT_LD;
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (wait_r > WW'(1)) begin
                        wait_r <= wait_r - WW'(1);
                    end else begin
                        wait_r  <= {WW{1'b0}};
                        state_r <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    m_data_r  <= bus.s_dout;
                    m_valid_r <= 1'b1;
                    if (bus.s_dout < vmin_r) begin
                        vmin_r <= bus.s_dout;
                    end
                    if (bus.s_dout > vmax_r) begin
                        vmax_r <= bus.s_dout;
                    end
                    if (violation_s) begin
                        order_err_r <= 1'b1;
                        err_index_r <= count_r;
                    end
                    count_r <= count_next_s;
                    state_r <= CHECK;
                end
                DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_pop     = s_pop_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.m_valid   = m_valid_r;
    assign bus.m_data    = m_data_r;
    assign bus.count     = count_r;
    assign bus.vmin      = vmin_r;
    assign bus.vmax      = vmax_r;
    assign bus.order_err = order_err_r;
    assign bus.err_index = err_index_r;

endmodule

// File: tb/tb_sort_drain_checker.sv
// Bench for sort_drain_checker: a queue-based sorter model feeds the DUT, and a
// word-level scoreboard recomputes the drain statistics from the popped words.
module tb_sort_drain_checker;
    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_drain_checker_if #(.DW(DW), .CW(CW)) bus ();

    sort_drain_checker #(.DW(DW), .CW(CW), .POP_WAIT(2), .GAP(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_tog  = 0;
    int n_done = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] tmp[$];

    int            mdl_cnt;
    logic [DW-1:0] mdl_min;
    logic [DW-1:0] mdl_max;
    logic [DW-1:0] mdl_last;
    bit            mdl_err;
    int            mdl_eidx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        mdl_cnt  = 0;
        mdl_min  = '1;
        mdl_max  = '0;
        mdl_last = '0;
        mdl_err  = 1'b0;
        mdl_eidx = 0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic load(input logic [DW-1:0] v[$], input bit srt);
        src_q.delete();
        foreach (v[i]) begin
            if (srt) begin
                int k = 0;
                while (k < src_q.size() && src_q[k] <= v[i]) k++;
                src_q.insert(k, v[i]);
            end else begin
                src_q.push_back(v[i]);
            end
        end
    endtask

    task automatic toggle_start();
        bus.start = ~bus.start;
    endtask

    task automatic wait_done(input string name);
        int base = n_done;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (n_done > base) break;
        end
        chk(name, 32'(n_done > base), 32'd1);
    endtask

    task automatic chk_rx(input string name, input logic [DW-1:0] e[$]);
        logic [31:0] a;
        chk({name, "_len"}, rx_q.size(), e.size());
        foreach (e[i]) begin
            a = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hxxxx_xxxx;
            chk($sformatf("%s_w%0d", name, i), a, 32'(e[i]));
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_s_pop"},     bus.s_pop,     32'd0);
        chk({p, "_busy"},      bus.busy,      32'd0);
        chk({p, "_done"},      bus.done,      32'd0);
        chk({p, "_m_valid"},   bus.m_valid,   32'd0);
        chk({p, "_m_data"},    bus.m_data,    32'd0);
        chk({p, "_count"},     bus.count,     32'd0);
        chk({p, "_vmin"},      bus.vmin,      32'hFFFF);
        chk({p, "_vmax"},      bus.vmax,      32'd0);
        chk({p, "_order_err"}, bus.order_err, 32'd0);
        chk({p, "_err_index"}, bus.err_index, 32'd0);
    endtask

    // Sorter model: every pop toggle hands out the next queued word on the following negedge.
    logic pop_q = 1'b0;
    always @(negedge clk) begin : sorter_model
        if (rst) begin
            pop_q = 1'b0;
        end else if (bus.s_pop !== pop_q) begin
            pop_q = bus.s_pop;
            if (src_q.size() > 0) begin
                bus.s_dout = src_q.pop_front();
                exp_q.push_back(bus.s_dout);
            end
        end
        bus.s_empty = (src_q.size() == 0);
    end

    logic en_q;
    always @(posedge clk) en_q <= bus.enable;

    // Scoreboard: each m_valid must carry the next popped word with statistics to match.
    logic prev_pop = 1'b0;
    always @(negedge clk) begin : compare
        logic [DW-1:0] w;
        int            sat;
        if (rst) begin
            prev_pop = 1'b0;
        end else begin
            if (en_q === 1'b0) begin
                chk("dis_m_valid", bus.m_valid, 32'd0);
                chk("dis_done",    bus.done,    32'd0);
                chk("dis_s_pop",   bus.s_pop,   32'(prev_pop));
            end
            if (bus.s_pop !== prev_pop) begin
                n_tog++;
                prev_pop = bus.s_pop;
            end
            if (bus.done === 1'b1) n_done++;
            if (bus.m_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected no word", bus.m_data);
                end else begin
                    w = exp_q.pop_front();
                    rx_q.push_back(bus.m_data);
                    chk("m_data", bus.m_data, 32'(w));
                    if (mdl_cnt > 0 && w < mdl_last && !mdl_err) begin
                        mdl_err  = 1'b1;
                        mdl_eidx = (mdl_cnt > 255) ? 255 : mdl_cnt;
                    end
                    mdl_cnt++;
                    if (w < mdl_min) mdl_min = w;
                    if (w > mdl_max) mdl_max = w;
                    mdl_last = w;
                    sat = (mdl_cnt > 255) ? 255 : mdl_cnt;
                    chk("count",     bus.count,     32'(sat));
                    chk("vmin",      bus.vmin,      32'(mdl_min));
                    chk("vmax",      bus.vmax,      32'(mdl_max));
                    chk("order_err", bus.order_err, 32'(mdl_err));
                    chk("err_index", bus.err_index, 32'(mdl_eidx));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int b_tog;
        int b_done;
        int k;
        bit hit;

        rst        = 1'b1;
        bus.enable = 1'b1;
        bus.start  = 1'b0;
        bus.s_idle = 1'b1;
        repeat (3) step();
        chk_reset("rst");
        rst = 1'b0;
        repeat (2) step();

        // Sorted drain of 5,3,9,1.
        tmp = {16'd5, 16'd3, 16'd9, 16'd1};
        load(tmp, 1'b1);
        mdl_clear();
        b_tog = n_tog; b_done = n_done;
        step();
        toggle_start();
        wait_done("t1_done");
        repeat (3) step();
        tmp = {16'd1, 16'd3, 16'd5, 16'd9};
        chk_rx("t1_rx", tmp);
        chk("t1_count", bus.count, 32'd4);
        chk("t1_vmin", bus.vmin, 32'd1);
        chk("t1_vmax", bus.vmax, 32'd9);
        chk("t1_order_err", bus.order_err, 32'd0);
        chk("t1_toggles", n_tog - b_tog, 32'd4);
        chk("t1_dones", n_done - b_done, 32'd1);

        // Empty sorter, s_idle held low for a while first.
        tmp.delete();
        load(tmp, 1'b0);
        mdl_clear();
        bus.s_idle = 1'b0;
        step();
        b_tog = n_tog; b_done = n_done;
        toggle_start();
        repeat (5) begin
            step();
            chk("t2_busy_wait", bus.busy, 32'd1);
        end
        chk("t2_no_early_done", n_done - b_done, 32'd0);
        bus.s_idle = 1'b1;
        hit = 1'b0;
        for (k = 1; k <= 6; k++) begin
            step();
            if (n_done > b_done) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t2_done_latency_ok", 32'(hit && k <= 3), 32'd1);
        repeat (3) step();
        chk("t2_count", bus.count, 32'd0);
        chk("t2_vmin", bus.vmin, 32'hFFFF);
        chk("t2_vmax", bus.vmax, 32'd0);
        chk("t2_toggles", n_tog - b_tog, 32'd0);
        chk("t2_busy", bus.busy, 32'd0);

        // Out-of-order words: first violation at index 2.
        tmp = {16'd2, 16'd7, 16'd4, 16'd8, 16'd1};
        load(tmp, 1'b0);
        mdl_clear();
        step();
        toggle_start();
        wait_done("t3_done");
        repeat (3) step();
        chk_rx("t3_rx", tmp);
        chk("t3_order_err", bus.order_err, 32'd1);
        chk("t3_err_index", bus.err_index, 32'd2);
        chk("t3_count", bus.count, 32'd5);
        chk("t3_vmin", bus.vmin, 32'd1);
        chk("t3_vmax", bus.vmax, 32'd8);

        // Start edges while busy and while disabled are dropped.
        tmp = {16'd6, 16'd4};
        load(tmp, 1'b1);
        mdl_clear();
        step();
        b_tog = n_tog; b_done = n_done;
        toggle_start();
        repeat (4) step();
        toggle_start();
        repeat (7) step();
        toggle_start();
        wait_done("t4_done");
        repeat (40) step();
        chk("t4_dones", n_done - b_done, 32'd1);
        chk("t4_toggles", n_tog - b_tog, 32'd2);
        bus.enable = 1'b0;
        toggle_start();
        repeat (3) step();
        bus.enable = 1'b1;
        repeat (40) step();
        chk("t4_dis_dones", n_done - b_done, 32'd1);
        chk("t4_dis_toggles", n_tog - b_tog, 32'd2);
        chk("t4_busy", bus.busy, 32'd0);
        tmp = {16'd4, 16'd6};
        chk_rx("t4_rx", tmp);

        // Enable dropped for 20 cycles in the middle of an 8-word drain.
        tmp = {16'd40, 16'd10, 16'd80, 16'd20, 16'd70, 16'd30, 16'd60, 16'd50};
        load(tmp, 1'b1);
        mdl_clear();
        step();
        toggle_start();
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (rx_q.size() >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t5_reached_3_words", 32'(hit), 32'd1);
        bus.enable = 1'b0;
        repeat (20) begin
            step();
            chk("t5_busy_held", bus.busy, 32'd1);
        end
        bus.enable = 1'b1;
        wait_done("t5_done");
        repeat (3) step();
        tmp = {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
        chk_rx("t5_rx", tmp);
        chk("t5_count", bus.count, 32'd8);

        // Reset during the wait after the third pop, then a clean drain.
        tmp = {16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
        load(tmp, 1'b1);
        mdl_clear();
        step();
        b_tog = n_tog;
        toggle_start();
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (n_tog - b_tog >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t6_reached_pop3", 32'(hit), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        chk_reset("t6_rst");
        src_q.delete();
        mdl_clear();
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();
        tmp = {16'd3, 16'd1, 16'd2};
        load(tmp, 1'b1);
        mdl_clear();
        step();
        b_tog = n_tog; b_done = n_done;
        toggle_start();
        wait_done("t6_done");
        repeat (3) step();
        tmp = {16'd1, 16'd2, 16'd3};
        chk_rx("t6_rx", tmp);
        chk("t6_count", bus.count, 32'd3);
        chk("t6_vmin", bus.vmin, 32'd1);
        chk("t6_vmax", bus.vmax, 32'd3);
        chk("t6_toggles", n_tog - b_tog, 32'd3);
        chk("t6_dones", n_done - b_done, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
